// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit core: opcodes, widths,
// and the fetch-stage state encoding.
package isa_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;
  localparam logic [PC_W-1:0] PC_INC = 16'd2;

  typedef enum logic [2:0] {
    OP_ADD    = 3'b000,
    OP_ADDI   = 3'b001,
    OP_SHIFT  = 3'b010,
    OP_ROTATE = 3'b011,
    OP_BEQ    = 3'b100,
    OP_SW     = 3'b101,
    OP_LW     = 3'b110,
    OP_JMP    = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DRAIN   = 2'd2,
    DISCARD = 2'd3
  } fetch_state_e;

  function automatic logic [2:0] opcode_of(
    input logic [INSTR_W-1:0] instr
  );
    return instr[INSTR_W-1 -: 3];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Single-entry IF/ID pipeline register: payload plus valid bit
// with load / flush / consume controls (flush wins).
module if_id_reg #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_flush,
  input  logic               i_consume,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc,
  input  logic [PC_W-1:0]    i_pc_next,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc,
  output logic [PC_W-1:0]    o_pc_next
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_pc_next;
  logic               w_take;

  assign w_take = i_load && !i_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  // Payload is only rewritten on a real capture, so it holds under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr   <= '0;
      r_pc      <= '0;
      r_pc_next <= '0;
    end else if (w_take) begin
      r_instr   <= i_instr;
      r_pc      <= i_pc;
      r_pc_next <= i_pc_next;
    end
  end

  assign o_valid   = r_valid;
  assign o_instr   = r_instr;
  assign o_pc      = r_pc;
  assign o_pc_next = r_pc_next;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, imem request FSM and IF/ID capture.
// Define INSTR_COUNT_EN to build the delivered-instruction counter.
module instr_fetch #(
  parameter int PC_W    = isa_pkg::PC_W,
  parameter int INSTR_W = isa_pkg::INSTR_W,
  parameter logic [PC_W-1:0] PC_INC   = PC_W'(isa_pkg::PC_INC),
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [2:0]         id_opcode,
  output logic [PC_W-1:0]    id_pc,
  output logic [PC_W-1:0]    id_pc_next,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [15:0]        instr_count
);

  import isa_pkg::*;

  fetch_state_e    r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_hold;

  logic            w_issue;
  logic            w_xfer;
  logic            w_redir;
  logic            w_load;
  logic [PC_W-1:0] w_tgt;
  logic [PC_W-1:0] w_pc_inc;

  // Issue only when IF/ID is free this cycle: one request in flight.
  assign w_issue  = (r_state == FETCH) &&
                    (!id_valid || id_ready);
  assign w_xfer   = id_valid && id_ready;
  assign w_redir  = redirect_valid && (r_state != IDLE);
  assign w_load   = w_issue && imem_ack && !w_redir;
  assign w_tgt    = redirect_pc & ~PC_W'(1);
  assign w_pc_inc = r_pc + PC_INC;

  assign imem_req  = w_issue || (r_state == DISCARD);
  assign imem_addr = (r_state == DISCARD) ? r_hold : r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_hold  <= RESET_PC;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_state <= FETCH;
        end
        FETCH: begin
          if (w_redir) begin
            r_pc <= w_tgt;
            if (w_issue && !imem_ack) begin
              r_state <= DISCARD;
              r_hold  <= r_pc;
            end
          end else if (w_load) begin
            r_pc <= w_pc_inc;
          end else if (!w_issue) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_redir) begin
            r_pc    <= w_tgt;
            r_state <= FETCH;
          end else if (id_ready) begin
            r_state <= FETCH;
          end
        end
        DISCARD: begin
          if (w_redir) begin
            r_pc <= w_tgt;
          end
          if (imem_ack) begin
            r_state <= FETCH;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  if_id_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_flush   (w_redir),
    .i_consume (w_xfer),
    .i_instr   (imem_rdata),
    .i_pc      (r_pc),
    .i_pc_next (w_pc_inc),
    .o_valid   (id_valid),
    .o_instr   (id_instr),
    .o_pc      (id_pc),
    .o_pc_next (id_pc_next)
  );

  assign id_opcode = opcode_of(id_instr);

`ifdef INSTR_COUNT_EN
  logic [15:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_xfer) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign instr_count = r_count;
`else
  assign instr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed phases push the
// expected delivered PCs, a monitor checks every IF/ID transfer.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [15:0] id_instr;
  logic [2:0]  id_opcode;
  logic [15:0] id_pc;
  logic [15:0] id_pc_next;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] instr_count;

  int n_chk = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  logic zw = 1'b1;
  logic mem_en = 1'b1;
  int   lat_cnt = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000) return 16'h2A41;
    return {a[7:0], ~a[7:0]};
  endfunction

  // Memory: zero-wait, or ack on the third cycle of a held request.
  assign imem_ack   = mem_en && imem_req && (zw || lat_cnt == 2);
  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clk) begin
    if (!imem_req || imem_ack) lat_cnt <= 0;
    else lat_cnt <= lat_cnt + 1;
  end

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_opcode      (id_opcode),
    .id_pc          (id_pc),
    .id_pc_next     (id_pc_next),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_count    (instr_count)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    logic [15:0] w;
    logic [15:0] en;
    logic [2:0]  op;
    if (!rst && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL xfer_unexpected actual pc=%h required none",
                 id_pc);
      end else begin
        e  = exp_q.pop_front();
        w  = mem_word(e);
        en = e + 16'd2;
        op = w[15:13];
        chk("xfer_pc", {16'h0, id_pc}, {16'h0, e});
        chk("xfer_instr", {16'h0, id_instr}, {16'h0, w});
        chk("xfer_pc_next", {16'h0, id_pc_next}, {16'h0, en});
        chk("xfer_opcode", {29'h0, id_opcode}, {29'h0, op});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", {16'h0, imem_addr}, 32'h0);
    chk("rst_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_instr", {16'h0, id_instr}, 32'h0);
    chk("rst_pc", {16'h0, id_pc}, 32'h0);
    chk("rst_pc_next", {16'h0, id_pc_next}, 32'h0);
    chk("rst_count", {16'h0, instr_count}, 32'h0);
    chk("queue_drained", exp_q.size(), 32'h0);
    exp_q.delete();
    cyc();
    cyc();
    mem_en = 1'b1;
    zw = 1'b1;
    id_ready = 1'b1;
    redirect_valid = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_cnt;
    #1;
    do_reset();

    // zero-wait streaming, then redirect with same-cycle ack
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0004);
    cyc(); settle();
    chk("p1_addr0", {16'h0, imem_addr}, 32'h0000);
    chk("p1_req0", {31'h0, imem_req}, 32'h1);
    chk("p1_valid0", {31'h0, id_valid}, 32'h0);
    cyc(); settle();
    chk("p1_addr2", {16'h0, imem_addr}, 32'h0002);
    chk("p1_idpc0", {16'h0, id_pc}, 32'h0000);
    chk("p1_opcode", {29'h0, id_opcode}, 32'h1);
    cyc(); settle();
    chk("p1_addr4", {16'h0, imem_addr}, 32'h0004);
    chk("p1_idpc2", {16'h0, id_pc}, 32'h0002);
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0041;
    settle();
    chk("p1_addr6", {16'h0, imem_addr}, 32'h0006);
    chk("p1_idpc4", {16'h0, id_pc}, 32'h0004);
    chk("p1_ack6", {31'h0, imem_ack}, 32'h1);
    cyc();
    redirect_valid = 1'b0;
    mem_en = 1'b0;
    settle();
    chk("p1_flush", {31'h0, id_valid}, 32'h0);
    chk("p1_tgt", {16'h0, imem_addr}, 32'h0040);
    do_reset();

    // backpressure, latency redirect, count, reset mid-request
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0004);
    exp_q.push_back(16'h0006);
    exp_q.push_back(16'h0100);
    cyc(); settle();
    chk("p2_addr0", {16'h0, imem_addr}, 32'h0000);
    cyc();
    id_ready = 1'b0;
    settle();
    chk("p2_valid", {31'h0, id_valid}, 32'h1);
    chk("p2_req_c2", {31'h0, imem_req}, 32'h0);
    cyc(); settle();
    chk("p2_req_c3", {31'h0, imem_req}, 32'h0);
    chk("p2_hold_instr", {16'h0, id_instr}, 32'h2A41);
    cyc(); settle();
    chk("p2_req_c4", {31'h0, imem_req}, 32'h0);
    chk("p2_no_adv", {16'h0, imem_addr}, 32'h0002);
    chk("p2_hold_pc", {16'h0, id_pc}, 32'h0000);
    cyc();
    id_ready = 1'b1;
    settle();
    chk("p2_req_c5", {31'h0, imem_req}, 32'h0);
    cyc(); settle();
    chk("p2_resume_req", {31'h0, imem_req}, 32'h1);
    chk("p2_resume_addr", {16'h0, imem_addr}, 32'h0002);
    cyc(); settle();
    chk("p2_addr4", {16'h0, imem_addr}, 32'h0004);
    cyc(); settle();
    chk("p2_addr6", {16'h0, imem_addr}, 32'h0006);
    cyc();
    zw = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0100;
    settle();
    chk("p4_addr8", {16'h0, imem_addr}, 32'h0008);
    chk("p4_noack", {31'h0, imem_ack}, 32'h0);
    cyc();
    redirect_valid = 1'b0;
    settle();
    chk("p4_disc_req", {31'h0, imem_req}, 32'h1);
    chk("p4_disc_addr", {16'h0, imem_addr}, 32'h0008);
    chk("p4_disc_flush", {31'h0, id_valid}, 32'h0);
    cyc(); settle();
    chk("p4_disc_addr2", {16'h0, imem_addr}, 32'h0008);
    chk("p4_disc_ack", {31'h0, imem_ack}, 32'h1);
    cyc();
    zw = 1'b1;
    settle();
    chk("p4_tgt_addr", {16'h0, imem_addr}, 32'h0100);
    chk("p4_dropped", {31'h0, id_valid}, 32'h0);
    cyc();
    zw = 1'b0;
    settle();
    chk("p4_tgt_pc", {16'h0, id_pc}, 32'h0100);
    chk("p4_addr102", {16'h0, imem_addr}, 32'h0102);
    cyc(); settle();
    chk("p6_pending", {31'h0, imem_req}, 32'h1);
`ifdef INSTR_COUNT_EN
    exp_cnt = 32'd5;
`else
    exp_cnt = 32'd0;
`endif
    chk("p6_count", {16'h0, instr_count}, exp_cnt);
    do_reset();

    // restart at RESET_PC, then wrap at the top of the space
    exp_q.push_back(16'hFFFE);
    exp_q.push_back(16'h0000);
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFF;
    settle();
    chk("p6_restart", {16'h0, imem_addr}, 32'h0000);
    chk("p6_restart_req", {31'h0, imem_req}, 32'h1);
    cyc();
    redirect_valid = 1'b0;
    settle();
    chk("p5_addr", {16'h0, imem_addr}, 32'hFFFE);
    chk("p5_flush", {31'h0, id_valid}, 32'h0);
    cyc(); settle();
    chk("p5_idpc", {16'h0, id_pc}, 32'hFFFE);
    chk("p5_pc_next", {16'h0, id_pc_next}, 32'h0000);
    chk("p5_wrap_addr", {16'h0, imem_addr}, 32'h0000);
    cyc();
    mem_en = 1'b0;
    settle();
    chk("p5_idpc0", {16'h0, id_pc}, 32'h0000);
    chk("p5_addr2", {16'h0, imem_addr}, 32'h0002);
    cyc(); settle();
    chk("p5_empty", {31'h0, id_valid}, 32'h0);
    chk("final_drained", exp_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
